// File: rtl/dmem_mmio_pkg.sv
// dmem_mmio_pkg
//   Shared address map and CTRL bit layout for the data-side responder.
//   Test programs use the same constants to reach the MMIO page.
//   Contents: MMIO page base, register byte addresses, register word
//   indices within the page, CTRL bit positions, the decoder-to-timer
//   write request struct and a page-hit helper.
package dmem_mmio_pkg;

    // 0x0000_FF00..0x0000_FF1F
    localparam logic [26:0] MMIO_PAGE = 27'h7F8;

    localparam logic [31:0] ADDR_LED  = 32'h0000_FF00;
    localparam logic [31:0] ADDR_SW   = 32'h0000_FF04;
    localparam logic [31:0] ADDR_CNT  = 32'h0000_FF08;
    localparam logic [31:0] ADDR_CTRL = 32'h0000_FF0C;
    localparam logic [31:0] ADDR_CMP  = 32'h0000_FF10;

    // Word index within the page (addr[4:2])
    typedef enum logic [2:0] {
        REG_LED  = 3'd0,
        REG_SW   = 3'd1,
        REG_CNT  = 3'd2,
        REG_CTRL = 3'd3,
        REG_CMP  = 3'd4
    } mmio_reg_e;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_OVF   = 1;
    localparam int CTRL_MATCH = 2;
    localparam int CTRL_IE    = 3;

    // Store request routed from the decoder to the timer
    typedef struct packed {
        logic        cnt_we;
        logic        ctrl_we;
        logic        cmp_we;
        logic [31:0] wdata;
    } tmr_wr_t;

    function automatic logic is_mmio(input logic [31:0] a);
        return a[31:5] == MMIO_PAGE;
    endfunction

endpackage

// File: rtl/dmem_mmio_timer.sv
// mmio_timer
//   Prescaled 32-bit timer with compare, sticky MATCH/OVF flags and a
//   level interrupt (IE & MATCH).
//   Ports:
//     clk, reset   clock, async active-low reset
//     wr           decoded store request (per-register write enables + data)
//     cnt, cmp     current CNT / CMP for readback
//     ctrl         CTRL readback {IE, MATCH, OVF, EN}, upper bits zero
//     irq          timer interrupt
module mmio_timer
    import dmem_mmio_pkg::*;
#(
    parameter int PRESCALE = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  tmr_wr_t     wr,
    output logic [31:0] cnt,
    output logic [31:0] cmp,
    output logic [31:0] ctrl,
    output logic        irq
);

    localparam int              PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_TOP = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps;
    logic            en, ie, ovf, match;
    logic            tick, hit_match, hit_ovf, clr_ovf, clr_match;

    // Tick is the prescaler's terminal count; it follows the registered EN.
    assign tick = en && (ps == PS_TOP);

    // A CPU write to CNT overrides the tick, so no flag is raised then.
    assign hit_match = tick && !wr.cnt_we && (cnt == cmp);
    assign hit_ovf   = tick && !wr.cnt_we && (cnt != cmp) && (&cnt);

    assign clr_ovf   = wr.ctrl_we && wr.wdata[CTRL_OVF];
    assign clr_match = wr.ctrl_we && wr.wdata[CTRL_MATCH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps    <= '0;
            cnt   <= '0;
            cmp   <= 32'hFFFF_FFFF;
            en    <= 1'b0;
            ie    <= 1'b0;
            ovf   <= 1'b0;
            match <= 1'b0;
        end else begin
            // Prescaler holds its phase while disabled
            if (en) ps <= tick ? '0 : ps + 1'b1;

            if (wr.cnt_we)
                cnt <= wr.wdata;
            else if (tick)
                cnt <= (hit_match || hit_ovf) ? 32'd0 : cnt + 32'd1;

            if (wr.cmp_we) cmp <= wr.wdata;

            if (wr.ctrl_we) begin
                en <= wr.wdata[CTRL_EN];
                ie <= wr.wdata[CTRL_IE];
            end

            // Hardware set beats a write-1-clear in the same cycle
            ovf   <= hit_ovf   | (ovf   & ~clr_ovf);
            match <= hit_match | (match & ~clr_match);
        end
    end

    assign ctrl = {28'd0, ie, match, ovf, en};
    assign irq  = ie & match;

endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio
//   Data-side responder for the single-cycle RISC-V core: word RAM plus an
//   MMIO page (LED, synchronised switches, timer). Loads are combinational
//   from addr; stores commit on the rising clk edge.
//   Ports:
//     clk, reset   clock, async active-low reset
//     memwrite     store strobe
//     addr         byte address (addr[1:0] ignored)
//     writedata    store data
//     readdata     load data, combinational
//     sw           raw switch pins (asynchronous)
//     led          LED register
//     irq          timer interrupt
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int RAM_WORDS = 256,
    parameter int PRESCALE  = 50,
    parameter int SW_W      = 16,
    parameter int LED_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [31:0]      addr,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] led,
    output logic             irq
);

    localparam int          IW       = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [29:0] IDX_MASK = 30'(RAM_WORDS - 1);

    logic [31:0]     mem [RAM_WORDS];
    logic [IW-1:0]   ram_idx;
    logic            ram_sel, page_sel;
    logic [2:0]      reg_idx;
    logic            led_we;
    logic [SW_W-1:0] sw_s1, sw_s2;
    tmr_wr_t         tmr_wr;
    logic [31:0]     tmr_cnt, tmr_cmp, tmr_ctrl;
    logic            unused_addr_lsb;

    assign unused_addr_lsb = ^addr[1:0];

    // Word-aligned decode: RAM when every word-address bit above the
    // index is zero, i.e. addr < RAM_WORDS*4.
    assign ram_sel  = ((addr[31:2] & ~IDX_MASK) == 30'd0);
    assign ram_idx  = IW'(addr[31:2] & IDX_MASK);
    assign page_sel = is_mmio(addr);
    assign reg_idx  = addr[4:2];

    assign led_we = memwrite && page_sel && (reg_idx == REG_LED);

    always_comb begin
        tmr_wr       = '0;
        tmr_wr.wdata = writedata;
        if (memwrite && page_sel) begin
            case (reg_idx)
                REG_CNT:  tmr_wr.cnt_we  = 1'b1;
                REG_CTRL: tmr_wr.ctrl_we = 1'b1;
                REG_CMP:  tmr_wr.cmp_we  = 1'b1;
                default:  ;
            endcase
        end
    end

    // RAM has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (memwrite && ram_sel) mem[ram_idx] <= writedata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led   <= '0;
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
            if (led_we) led <= writedata[LED_W-1:0];
        end
    end

    mmio_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .wr    (tmr_wr),
        .cnt   (tmr_cnt),
        .cmp   (tmr_cmp),
        .ctrl  (tmr_ctrl),
        .irq   (irq)
    );

    // Loads see pre-edge state, so a same-cycle store returns the old value.
    always_comb begin
        readdata = 32'd0;
        if (ram_sel) begin
            readdata = mem[ram_idx];
        end else if (page_sel) begin
            case (reg_idx)
                REG_LED:  readdata = 32'(led);
                REG_SW:   readdata = 32'(sw_s2);
                REG_CNT:  readdata = tmr_cnt;
                REG_CTRL: readdata = tmr_ctrl;
                REG_CMP:  readdata = tmr_cmp;
                default:  readdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;
    import dmem_mmio_pkg::*;

    localparam int RAM_WORDS = 64;
    localparam int PRESCALE  = 3;
    localparam int SW_W      = 16;
    localparam int LED_W     = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             memwrite = 1'b0;
    logic [31:0]      addr = 32'd0;
    logic [31:0]      writedata = 32'd0;
    logic [31:0]      readdata;
    logic [SW_W-1:0]  sw = '0;
    logic [LED_W-1:0] led;
    logic             irq;

    always #5 clk = ~clk;

    dmem_mmio #(
        .RAM_WORDS (RAM_WORDS),
        .PRESCALE  (PRESCALE),
        .SW_W      (SW_W),
        .LED_W     (LED_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .sw        (sw),
        .led       (led),
        .irq       (irq)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0]     m_ram [RAM_WORDS];
    bit              m_vld [RAM_WORDS];
    logic [LED_W-1:0] m_led;
    logic [SW_W-1:0] m_s1, m_s2;
    logic [31:0]     m_cnt, m_cmp;
    bit              m_en, m_ie, m_ovf, m_match;
    int              m_ps;

    task automatic m_reset();
        m_led = '0; m_s1 = '0; m_s2 = '0;
        m_cnt = 32'd0; m_cmp = 32'hFFFF_FFFF;
        m_en = 0; m_ie = 0; m_ovf = 0; m_match = 0; m_ps = 0;
    endtask

    function automatic bit m_tick();
        return m_en && (m_ps == PRESCALE - 1);
    endfunction

    task automatic m_read(input logic [31:0] a, output logic [31:0] v, output bit known);
        logic [31:0] w;
        w = a & ~32'd3;
        known = 1;
        v = 32'd0;
        if (w < 32'(RAM_WORDS * 4)) begin
            known = m_vld[int'(w >> 2)];
            v     = m_ram[int'(w >> 2)];
        end else if (w >= 32'h0000_FF00 && w <= 32'h0000_FF1F) begin
            case (w)
                32'h0000_FF00: v = 32'(m_led);
                32'h0000_FF04: v = 32'(m_s2);
                32'h0000_FF08: v = m_cnt;
                32'h0000_FF0C: v = {28'd0, m_ie, m_match, m_ovf, m_en};
                32'h0000_FF10: v = m_cmp;
                default:       v = 32'd0;
            endcase
        end
    endtask

    task automatic m_step(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [SW_W-1:0] swv);
        logic [31:0] w;
        bit t, set_m, set_o;
        w = a & ~32'd3;
        t = m_tick();
        set_m = 0; set_o = 0;
        if (m_en) m_ps = (m_ps + 1) % PRESCALE;
        if (we && w == 32'h0000_FF08) m_cnt = wd;
        else if (t) begin
            if (m_cnt == m_cmp) begin set_m = 1; m_cnt = 0; end
            else if (m_cnt == 32'hFFFF_FFFF) begin set_o = 1; m_cnt = 0; end
            else m_cnt = m_cnt + 1;
        end
        if (we && w == 32'h0000_FF0C) begin
            if (wd[1]) m_ovf = 0;
            if (wd[2]) m_match = 0;
            m_en = wd[0];
            m_ie = wd[3];
        end
        if (set_m) m_match = 1;
        if (set_o) m_ovf = 1;
        if (we && w == 32'h0000_FF10) m_cmp = wd;
        if (we && w == 32'h0000_FF00) m_led = wd[LED_W-1:0];
        if (we && w < 32'(RAM_WORDS * 4)) begin
            m_ram[int'(w >> 2)] = wd;
            m_vld[int'(w >> 2)] = 1;
        end
        m_s2 = m_s1;
        m_s1 = swv;
    endtask

    // One bus cycle: drive, check combinational outputs, advance a clock.
    // Entered and left at posedge+1.
    task automatic cyc(input bit we, input logic [31:0] a, input logic [31:0] wd, input string tag);
        logic [31:0] ev;
        bit kn;
        memwrite = we; addr = a; writedata = wd;
        #1;
        m_read(a, ev, kn);
        if (kn) chk(tag, readdata, ev);
        chk("irq", {31'd0, irq}, {31'd0, m_ie & m_match});
        chk("led", 32'(led), 32'(m_led));
        @(posedge clk);
        m_step(we, a, wd, sw);
        #1;
        memwrite = 0;
    endtask

    task automatic peek(input logic [31:0] a, input string tag, input logic [31:0] exp);
        memwrite = 0; addr = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    logic [31:0] seq_q [$];
    logic [31:0] last;
    bit found;
    int r;
    logic [31:0] ra, rw;
    bit rwe;

    initial begin
        for (int i = 0; i < RAM_WORDS; i++) m_vld[i] = 0;
        m_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        peek(ADDR_LED,  "rst_led_reg", 32'd0);
        peek(ADDR_CTRL, "rst_ctrl",    32'd0);
        peek(ADDR_CMP,  "rst_cmp",     32'hFFFF_FFFF);
        peek(ADDR_CNT,  "rst_cnt",     32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        @(posedge clk); #1;
        reset = 1;
        cyc(0, ADDR_CMP, 0, "post_rst_cmp");

        // RAM
        cyc(1, 32'h10, 32'hDEAD_BEEF, "st_ram");
        cyc(0, 32'h10, 0, "ld_10");
        peek(32'h10, "ld_10_k", 32'hDEAD_BEEF);
        peek(32'h13, "ld_13_k", 32'hDEAD_BEEF);
        cyc(0, 32'h500, 0, "ld_500");
        peek(32'h500, "ld_500_k", 32'd0);
        cyc(1, 32'h500, 32'h1234_5678, "st_500");
        peek(32'h500, "reld_500_k", 32'd0);
        cyc(1, 32'h10, 32'h0BAD_F00D, "st_same_cyc");   // load sees old value
        peek(32'h10, "ld_new_k", 32'h0BAD_F00D);
        cyc(1, 32'hFC, 32'hCAFE_0001, "st_top");
        cyc(0, 32'hFC, 0, "ld_top");
        cyc(1, ADDR_LED, 32'hFFFF_1234, "st_led");
        chk("led_val", 32'(led), 32'h1234);
        cyc(1, ADDR_SW, 32'hFFFF_FFFF, "st_sw_ro");

        // Switch synchroniser lag
        sw = 16'hA5A5;
        for (int k = 0; k < 4; k++) begin
            peek(ADDR_SW, "sw_lag", (k >= 2) ? 32'h0000_A5A5 : 32'h0);
            cyc(0, ADDR_SW, 0, "sw_rd");
        end

        // Timer: compare/match
        cyc(1, ADDR_CMP, 3, "w_cmp");
        cyc(1, ADDR_CNT, 0, "w_cnt");
        cyc(1, ADDR_CTRL, 32'h9, "w_ctrl");
        last = 32'd0;
        for (int i = 0; i < 40 && seq_q.size() < 4; i++) begin
            cyc(0, ADDR_CNT, 0, "cnt_run");
            if (readdata !== last) begin
                seq_q.push_back(readdata);
                last = readdata;
            end
        end
        chk("seq_len", 32'(seq_q.size()), 32'd4);
        for (int i = 0; i < seq_q.size() && i < 4; i++)
            chk("cnt_seq", seq_q[i], (i == 3) ? 32'd0 : 32'(i + 1));
        peek(ADDR_CTRL, "match_set", 32'hD);
        chk("irq_on", {31'd0, irq}, 32'd1);
        @(posedge clk); m_step(0, ADDR_CTRL, 0, sw); #1;
        cyc(1, ADDR_CTRL, 32'hD, "clr_match");
        chk("irq_off", {31'd0, irq}, 32'd0);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (m_tick() && m_cnt == m_cmp) begin
                cyc(1, ADDR_CTRL, 32'hD, "clr_vs_set");
                found = 1;
            end else cyc(0, ADDR_CTRL, 0, "wait_hit");
        end
        chk("hit_found", {31'd0, found}, 32'd1);
        peek(ADDR_CTRL, "set_wins", 32'hD);
        chk("set_wins_irq", {31'd0, irq}, 32'd1);
        @(posedge clk); m_step(0, ADDR_CTRL, 0, sw); #1;

        // Timer: overflow
        cyc(1, ADDR_CTRL, 32'h6, "dis");
        cyc(1, ADDR_CMP, 5, "w_cmp5");
        cyc(1, ADDR_CNT, 32'hFFFF_FFFE, "w_cnt_big");
        cyc(1, ADDR_CTRL, 32'h1, "en");
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc(0, ADDR_CNT, 0, "ovf_run");
            found = m_ovf;
        end
        chk("ovf_found", {31'd0, found}, 32'd1);
        peek(ADDR_CNT,  "ovf_cnt",  32'd0);
        peek(ADDR_CTRL, "ovf_ctrl", 32'h3);
        @(posedge clk); m_step(0, ADDR_CTRL, 0, sw); #1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_tick()) begin
                cyc(1, ADDR_CNT, 7, "w_cnt_tick");
                found = 1;
            end else cyc(0, ADDR_CNT, 0, "wait_tick");
        end
        chk("tick_found", {31'd0, found}, 32'd1);
        peek(ADDR_CNT,  "cnt_wins",  32'd7);
        peek(ADDR_CTRL, "no_flag",   32'h3);
        @(posedge clk); m_step(0, ADDR_CTRL, 0, sw); #1;

        // Async reset mid-count
        cyc(1, ADDR_CTRL, 32'h6, "dis2");
        cyc(1, ADDR_CMP, 2, "w_cmp2");
        cyc(1, ADDR_CNT, 0, "w_cnt0");
        cyc(1, ADDR_CTRL, 32'h9, "en_ie");
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc(0, ADDR_CTRL, 0, "wait_m");
            found = m_match;
        end
        chk("m_found", {31'd0, found}, 32'd1);
        cyc(1, ADDR_CNT, 9, "w_cnt9");
        peek(ADDR_CNT, "pre_rst_cnt", 32'd9);
        chk("pre_rst_irq", {31'd0, irq}, 32'd1);
        reset = 0;
        #1;
        chk("arst_cnt", readdata, 32'd0);
        peek(ADDR_CTRL, "arst_ctrl", 32'd0);
        chk("arst_irq", {31'd0, irq}, 32'd0);
        peek(ADDR_CMP, "arst_cmp", 32'hFFFF_FFFF);
        m_reset();
        @(posedge clk); #1;
        reset = 1;

        // Randomised traffic
        cyc(1, ADDR_CMP, 4, "r_cmp");
        cyc(1, ADDR_CTRL, 32'h9, "r_en");
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       ra = $urandom_range(0, RAM_WORDS * 4 + 15);
            else if (r < 8)  ra = 32'h0000_FF00 + $urandom_range(0, 31);
            else if (r == 8) ra = 32'h0000_FF20 + $urandom_range(0, 63);
            else             ra = $urandom;
            rwe = ($urandom_range(0, 2) == 0);
            rw  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 12) : $urandom;
            if ((ra & ~32'd3) == ADDR_CTRL && $urandom_range(0, 1) == 1) rw[0] = 1'b1;
            if ($urandom_range(0, 15) == 0) sw = SW_W'($urandom);
            cyc(rwe, ra, rw, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
